// File: rtl/apb4_cmd_master.sv
// APB4 master engine: buffered valid/ready commands become APB4 SETUP/ACCESS transfers, results return via a 2-entry FWFT FIFO.
// Optional ACCESS watchdog is enabled by defining APB4_CMD_MASTER_TIMEOUT_EN.
module apb4_cmd_master #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int CMD_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  input  logic [2:0]          cmd_prot,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrb,
  output logic [2:0]          pprot,
  input  logic                pready,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pslverr,
  output logic                busy
);

  localparam int SW    = DATA_W / 8;
  localparam int AW    = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int CW    = AW + 1;
  localparam int CMD_W = 1 + ADDR_W + DATA_W + SW + 3;
  localparam logic [CW-1:0] CMD_FULL = CW'(CMD_DEPTH);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state;

  // command FIFO
  logic [CMD_W-1:0]  cmd_mem [CMD_DEPTH];
  logic [AW-1:0]     cmd_wr_ptr, cmd_rd_ptr;
  logic [CW-1:0]     cmd_cnt;
  logic              init_done;
  logic              cmd_push, cmd_pop, cmd_empty;
  logic              hd_write;
  logic [ADDR_W-1:0] hd_addr;
  logic [DATA_W-1:0] hd_wdata;
  logic [SW-1:0]     hd_strb;
  logic [2:0]        hd_prot;

  // cmd_ready stays low until the first edge after reset release
  assign cmd_ready = init_done && (cmd_cnt != CMD_FULL);
  assign cmd_push  = cmd_valid && cmd_ready;
  assign cmd_empty = (cmd_cnt == '0);
  assign {hd_write, hd_addr, hd_wdata, hd_strb, hd_prot} = cmd_mem[cmd_rd_ptr];

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) init_done <= 1'b0;
    else        init_done <= 1'b1;
  end

  always_ff @(posedge pclk) begin
    if (cmd_push) cmd_mem[cmd_wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot};
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      cmd_wr_ptr <= '0;
      cmd_rd_ptr <= '0;
      cmd_cnt    <= '0;
    end else begin
      if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + 1'b1;
      if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + 1'b1;
      cmd_cnt <= cmd_cnt + CW'(cmd_push) - CW'(cmd_pop);
    end
  end

  // response FIFO (2 entries, first-word fall-through)
  logic [DATA_W-1:0] rsp_data_mem [2];
  logic              rsp_err_mem  [2];
  logic              rsp_to_mem   [2];
  logic              rsp_wr_ptr, rsp_rd_ptr;
  logic [1:0]        rsp_cnt, rsp_cnt_next;
  logic              rsp_push, rsp_pop;
  logic              done, abort, credit, launch;
  logic [DATA_W-1:0] rsp_data_in;

  assign rsp_valid    = (rsp_cnt != 2'd0);
  assign rsp_pop      = rsp_valid && rsp_ready;
  assign rsp_cnt_next = rsp_cnt + 2'(rsp_push) - 2'(rsp_pop);
  assign rsp_rdata    = rsp_valid ? rsp_data_mem[rsp_rd_ptr] : '0;
  assign rsp_err      = rsp_valid && rsp_err_mem[rsp_rd_ptr];

`ifdef APB4_CMD_MASTER_TIMEOUT_EN
  logic [15:0] wait_cnt;

  assign abort       = (state == ACCESS) && !pready && (wait_cnt == 16'(TIMEOUT_CYC));
  assign rsp_timeout = rsp_valid && rsp_to_mem[rsp_rd_ptr];

  always_ff @(posedge pclk or posedge preset) begin
    if (preset)                                      wait_cnt <= '0;
    else if (state == SETUP)                         wait_cnt <= '0;
    else if (state == ACCESS && !pready && !abort)   wait_cnt <= wait_cnt + 16'd1;
  end
`else
  logic unused_to;

  assign abort       = 1'b0;
  assign rsp_timeout = 1'b0;
  assign unused_to   = rsp_to_mem[rsp_rd_ptr];
`endif

  assign done        = (state == ACCESS) && pready;
  assign rsp_push    = done || abort;
  assign rsp_data_in = (done && !pwrite) ? prdata : '0;
  // a launch reserves the response slot its own completion will need
  assign credit      = (rsp_cnt_next < 2'd2);
  assign launch      = !cmd_empty && credit && ((state == IDLE) || done);
  assign cmd_pop     = launch;

  always_ff @(posedge pclk) begin
    if (rsp_push) begin
      rsp_data_mem[rsp_wr_ptr] <= rsp_data_in;
      rsp_err_mem[rsp_wr_ptr]  <= abort || pslverr;
      rsp_to_mem[rsp_wr_ptr]   <= abort;
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      rsp_wr_ptr <= 1'b0;
      rsp_rd_ptr <= 1'b0;
      rsp_cnt    <= 2'd0;
    end else begin
      if (rsp_push) rsp_wr_ptr <= ~rsp_wr_ptr;
      if (rsp_pop)  rsp_rd_ptr <= ~rsp_rd_ptr;
      rsp_cnt <= rsp_cnt_next;
    end
  end

  // transfer FSM with registered APB outputs
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state   <= IDLE;
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
      pstrb   <= '0;
      pprot   <= '0;
    end else begin
      unique case (state)
        IDLE, ACCESS: begin
          if (launch) begin
            state   <= SETUP;
            psel    <= 1'b1;
            penable <= 1'b0;
            pwrite  <= hd_write;
            paddr   <= hd_addr;
            pwdata  <= hd_write ? hd_wdata : '0;
            pstrb   <= hd_write ? hd_strb : '0;
            pprot   <= hd_prot;
          end else if (state == ACCESS && rsp_push) begin
            state   <= IDLE;
            psel    <= 1'b0;
            penable <= 1'b0;
            pstrb   <= '0;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = !cmd_empty || (state != IDLE) || rsp_valid;

endmodule

// File: tb/tb_apb4_cmd_master.sv
// Directed bench for apb4_cmd_master: table-driven single transfers plus FIFO-full, backpressure, timeout and reset sequences.
module tb_apb4_cmd_master;

  localparam logic [31:0] XK = 32'hA5A5_0000;

  logic        pclk, preset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic        pready, pslverr, busy;
  logic        pready_r, pslverr_r, auto_slave;
  logic [31:0] prdata_r;

  int checks = 0;
  int errors = 0;
  logic [31:0] got_data[$];
  int          got_cyc[$];

  assign pready  = pready_r;
  assign pslverr = pslverr_r;
  assign prdata  = auto_slave ? (paddr ^ XK) : prdata_r;

  apb4_cmd_master #(.ADDR_W(32), .DATA_W(32), .CMD_DEPTH(4), .TIMEOUT_CYC(8)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready), .prdata(prdata), .pslverr(pslverr), .busy(busy)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          waits;
    logic [31:0] prdata;
    logic        slverr;
    logic [31:0] exp_pwdata;
    logic [3:0]  exp_pstrb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic drive_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [2:0] p);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_strb  = s;
    cmd_prot  = p;
  endtask

  // samples the response head, then lets the edge pop it (rsp_ready held by caller)
  task automatic collect(input int n, input int budget);
    int cyc;
    got_data.delete();
    got_cyc.delete();
    cyc = 0;
    while (got_data.size() < n && cyc < budget) begin
      if (rsp_valid) begin
        got_data.push_back(rsp_rdata);
        got_cyc.push_back(cyc);
      end
      tick();
      cyc++;
    end
  endtask

  task automatic run_single(input vec_t v, input int idx);
    drive_cmd(v.write, v.addr, v.wdata, v.strb, v.prot);
    prdata_r  = v.prdata;
    pslverr_r = v.slverr;
    pready_r  = 1'b0;
    check($sformatf("v%0d cmd_ready", idx), cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    check($sformatf("v%0d psel_n0", idx), psel, 1'b0);
    tick();
    check($sformatf("v%0d setup_psel", idx), psel, 1'b1);
    check($sformatf("v%0d setup_penable", idx), penable, 1'b0);
    check($sformatf("v%0d setup_paddr", idx), paddr, v.addr);
    check($sformatf("v%0d setup_pwrite", idx), pwrite, v.write);
    check($sformatf("v%0d setup_pwdata", idx), pwdata, v.exp_pwdata);
    check($sformatf("v%0d setup_pstrb", idx), pstrb, v.exp_pstrb);
    check($sformatf("v%0d setup_pprot", idx), pprot, v.prot);
    for (int k = 0; k <= v.waits; k++) begin
      tick();
      check($sformatf("v%0d access%0d_sel_en", idx, k), {psel, penable}, 2'b11);
      check($sformatf("v%0d access%0d_fields", idx, k),
            {paddr, pwdata}, {v.addr, v.exp_pwdata});
      check($sformatf("v%0d access%0d_strb_prot_wr", idx, k),
            {pstrb, pprot, pwrite}, {v.exp_pstrb, v.prot, v.write});
      check($sformatf("v%0d access%0d_no_rsp", idx, k), rsp_valid, 1'b0);
      pready_r = (k == v.waits);
    end
    tick();
    pready_r = 1'b0;
    check($sformatf("v%0d idle_sel_en_strb", idx), {psel, penable, pstrb}, 6'b0);
    check($sformatf("v%0d idle_paddr_hold", idx), paddr, v.addr);
    check($sformatf("v%0d rsp_valid", idx), rsp_valid, 1'b1);
    check($sformatf("v%0d rsp_rdata", idx), rsp_rdata, v.exp_rdata);
    check($sformatf("v%0d rsp_err", idx), rsp_err, v.exp_err);
    check($sformatf("v%0d rsp_timeout", idx), rsp_timeout, 1'b0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check($sformatf("v%0d rsp_popped", idx), rsp_valid, 1'b0);
    check($sformatf("v%0d not_busy", idx), busy, 1'b0);
  endtask

  initial begin
    int xfers;
    int acc;
    int seen;

    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'b010, 0, 32'hCAFE_F00D, 1'b0,
                32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_0020, 32'hFFFF_FFFF, 4'hF, 3'b001, 3, 32'h1234_5678, 1'b1,
                32'h0, 4'h0, 32'h1234_5678, 1'b1};
    vecs[2] = '{1'b1, 32'h8000_0004, 32'h0000_A5A5, 4'h3, 3'b111, 1, 32'h55AA_55AA, 1'b1,
                32'h0000_A5A5, 4'h3, 32'h0, 1'b1};
    vecs[3] = '{1'b0, 32'hFFFF_FFFC, 32'h1111_1111, 4'hC, 3'b000, 0, 32'h89AB_CDEF, 1'b0,
                32'h0, 4'h0, 32'h89AB_CDEF, 1'b0};

    preset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0;
    rsp_ready = 1'b0; pready_r = 1'b0; pslverr_r = 1'b0; prdata_r = '0; auto_slave = 1'b0;

    tick();
    tick();
    check("reset apb outputs", {psel, penable, pstrb, paddr}, '0);
    check("reset rsp outputs", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, '0);
    check("reset cmd_ready busy", {cmd_ready, busy}, 2'b00);
    preset = 1'b0;
    tick();
    check("post-reset cmd_ready", cmd_ready, 1'b1);

    for (int i = 0; i < 4; i++) run_single(vecs[i], i);

    // command FIFO fill with a stalled slave
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("fill ready%0d", i), cmd_ready, 1'b1);
      drive_cmd(1'b0, 32'h100 + 32'(i * 4), '0, 4'h0, 3'b000);
      tick();
    end
    drive_cmd(1'b0, 32'h200, '0, 4'h0, 3'b000);
    check("fill full ready", cmd_ready, 1'b0);
    tick();
    tick();
    check("fill still full", cmd_ready, 1'b0);
    check("fill busy", busy, 1'b1);
    cmd_valid = 1'b0;
    auto_slave = 1'b1;
    pready_r = 1'b1;
    collect(5, 40);
    check("fill rsp count", got_data.size(), 5);
    for (int i = 0; i < got_data.size(); i++) begin
      check($sformatf("fill rdata%0d", i), got_data[i], (32'h100 + 32'(i * 4)) ^ XK);
      if (i > 0) check($sformatf("fill spacing%0d", i), got_cyc[i] - got_cyc[i-1], 2);
    end
    tick();
    check("fill drained busy", busy, 1'b0);
    check("fill drained ready", cmd_ready, 1'b1);

    // response backpressure
    rsp_ready = 1'b0;
    xfers = 0;
    for (int c = 0; c < 12; c++) begin
      if (c < 4) drive_cmd(1'b0, 32'h300 + 32'(c * 4), '0, 4'h0, 3'b000);
      else cmd_valid = 1'b0;
      tick();
      if (psel && penable) xfers++;
    end
    check("bp transfers", xfers, 2);
    check("bp psel idle", psel, 1'b0);
    check("bp rsp head", {rsp_valid, rsp_rdata}, {1'b1, 32'h300 ^ XK});
    check("bp busy", busy, 1'b1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp resume setup", {psel, penable}, 2'b10);
    check("bp resume paddr", paddr, 32'h308);
    check("bp next head", rsp_rdata, 32'h304 ^ XK);
    rsp_ready = 1'b1;
    collect(3, 20);
    check("bp rsp count", got_data.size(), 3);
    for (int i = 0; i < got_data.size(); i++)
      check($sformatf("bp rdata%0d", i), got_data[i], (32'h304 + 32'(i * 4)) ^ XK);
    auto_slave = 1'b0;
    pready_r = 1'b0;
    tick();
    check("bp drained busy", busy, 1'b0);

`ifdef APB4_CMD_MASTER_TIMEOUT_EN
    rsp_ready = 1'b1;
    prdata_r = 32'h7777_7777;
    drive_cmd(1'b0, 32'h40, '0, 4'h0, 3'b000);
    tick();
    drive_cmd(1'b1, 32'h44, 32'h0BAD_F00D, 4'hF, 3'b000);
    tick();
    cmd_valid = 1'b0;
    acc = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (psel && penable) acc++;
      else if (acc > 0) break;
    end
    check("to access cycles", acc, 9);
    check("to aborted psel", {psel, penable}, 2'b00);
    check("to rsp", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout}, {1'b1, 32'h0, 1'b1, 1'b1});
    tick();
    check("to next setup", {psel, penable, paddr}, {2'b10, 32'h44});
    pready_r = 1'b1;
    tick();
    tick();
    pready_r = 1'b0;
    check("to next rsp", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout}, {1'b1, 32'h0, 1'b0, 1'b0});
    tick();
    rsp_ready = 1'b0;
`endif

    // reset during the second ACCESS cycle
    rsp_ready = 1'b0;
    pready_r = 1'b0;
    drive_cmd(1'b0, 32'h500, '0, 4'h0, 3'b000);
    tick();
    drive_cmd(1'b1, 32'h504, 32'h1, 4'h1, 3'b000);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    check("rst pre access", {psel, penable}, 2'b11);
    preset = 1'b1;
    #1;
    check("rst async apb", {psel, penable, pstrb, paddr}, '0);
    check("rst async status", {rsp_valid, busy, cmd_ready}, 3'b000);
    tick();
    tick();
    preset = 1'b0;
    tick();
    check("rst release ready", cmd_ready, 1'b1);
    check("rst release idle", {busy, psel, rsp_valid}, 3'b000);
    pready_r = 1'b1;
    rsp_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (rsp_valid || psel) seen++;
    end
    check("rst no activity", seen, 0);
    pready_r = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
